prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/prefetch_unit.sv | 94 +++++++++
 tb/tb_prefetch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the buffer entry type for the instruction prefetch unit.
package fetch_pkg;
  localparam int INST_W   = 32;
  localparam int XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  // pc is stored at the default width; narrower XLEN values zero-extend into it.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetched instructions with flush.
// Simultaneous push and pop are legal at any occupancy, including full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy tracking; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: credit-limited sequential fetch into a small buffer,
// with redirect handling that drops responses already in flight.
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]   outstanding, out_nxt, discard_cnt, occ;
  logic [CW:0]     inflight;
  logic            fire, rsp_live, keep, push, pop, full, empty;
  fetch_entry_t    wentry, rentry;

  // Buffered plus in-flight words never exceed the buffer size, so a
  // response always has a slot to land in.
  assign inflight       = {1'b0, occ} + {1'b0, outstanding};
  assign imem_req_valid = reset && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding belongs to a request abandoned by reset.
  assign rsp_live = imem_rsp_valid && (outstanding != '0);
  assign keep     = rsp_live && (discard_cnt == '0) && !redirect_valid;
  assign push     = keep && (!full || pop);
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  assign wentry.pc   = XLEN_DEF'(rsp_pc);
  assign wentry.inst = imem_rsp_data;

  assign inst_valid = reset && !empty;
  assign inst_data  = rentry.inst;
  assign inst_pc    = XLEN'(rentry.pc);

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (rentry),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  // Outstanding request count after this cycle's fire and response.
  always_comb begin
    out_nxt = outstanding;
    if (fire && !rsp_live)      out_nxt = outstanding + CW'(1);
    else if (!fire && rsp_live) out_nxt = outstanding - CW'(1);
  end

  // PC, credit and discard state; a redirect marks every in-flight word stale.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        fetch_pc    <= redirect_pc;
        rsp_pc      <= redirect_pc;
        discard_cnt <= out_nxt;
      end else begin
        if (fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_live) begin
          if (discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
          else                   rsp_pc      <= rsp_pc + XLEN'(4);
        end
      end
    end
  end
endmodule

// File: tb/tb_prefetch_unit.sv
// Randomized bench for prefetch_unit against a queue-based reference model.
module tb_prefetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;

  prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit live; } pend_t;

  pend_t       pend[$];     // requests the memory still owes, in order
  logic [31:0] bufq[$];     // PCs decode should see, in order
  logic [31:0] next_addr = '0;
  int n_chk = 0, n_err = 0;
  int cyc = 0, last_due = 0, fires = 0;
  int lat_lo = 1, lat_hi = 1;
  bit rst_drv = 0, rdy = 0, irdy = 0, redir = 0, junk = 0;
  logic [31:0] redir_pc = '0;
  bit stall_prev = 0;
  logic [31:0] stall_addr = '0;
  bit track = 0;
  int ff_cyc = -1, fv_cyc = -1;
  bit saw_wrap = 0;
  logic [31:0] last_fire = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit    exp_req, got_rsp, fire_m, pop_m;
    pend_t e;
    int    due;
    @(negedge clk);
    reset   = rst_drv;
    exp_req = rst_drv && ((bufq.size() + pend.size()) < DEPTH);
    got_rsp = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst_drv) pend.delete();
    if (junk && pend.size() == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEADBEEF;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      e = pend.pop_front();
      got_rsp = 1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(e.addr);
    end
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    #1;
    if (!rst_drv) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      bufq.delete();
      next_addr  = 32'h0;
      last_due   = 0;
      stall_prev = 0;
    end else begin
      chk("req_valid", imem_req_valid, exp_req);
      if (stall_prev) chk("req_hold", imem_req_addr, stall_addr);
      chk("inst_valid", inst_valid, bufq.size() > 0);
      if (inst_valid && bufq.size() > 0) begin
        chk("inst_pc", inst_pc, bufq[0]);
        chk("inst_data", inst_data, inst_of(bufq[0]));
      end
      fire_m = imem_req_valid && imem_req_ready;
      if (fire_m) begin
        chk("req_addr", imem_req_addr, next_addr);
        if (imem_req_addr == 32'h0 && last_fire == 32'hFFFFFFFC) saw_wrap = 1;
        last_fire = imem_req_addr;
        next_addr = next_addr + 32'd4;
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (due < last_due) due = last_due;
        last_due = due;
        pend.push_back('{imem_req_addr, due, 1'b1});
        fires++;
        if (track && ff_cyc < 0) ff_cyc = cyc;
      end
      if (track && inst_valid && fv_cyc < 0) fv_cyc = cyc;
      pop_m = inst_valid && inst_ready && !redir && bufq.size() > 0;
      if (pop_m) void'(bufq.pop_front());
      if (got_rsp && e.live && !redir) bufq.push_back(e.addr);
      if (redir) begin
        bufq.delete();
        foreach (pend[i]) pend[i].live = 0;
        next_addr = redir_pc;
      end
      stall_prev = imem_req_valid && !imem_req_ready && !redir;
      stall_addr = imem_req_addr;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redir = 1; redir_pc = pc;
    step();
    redir = 0;
  endtask

  initial begin
    // Reset with stray responses on the bus.
    rst_drv = 0; junk = 1; rdy = 1; irdy = 1;
    run(3);
    // Streaming with 1-cycle memory; a stray response in the first cycle is ignored.
    rst_drv = 1; track = 1; lat_lo = 1; lat_hi = 1;
    step();
    junk = 0;
    run(9);
    track = 0;
    chk("first_latency", 64'(fv_cyc - ff_cyc), 2);
    // Mid-operation reset, then fill with decode stalled.
    rst_drv = 0; run(2);
    rst_drv = 1; irdy = 0; fires = 0;
    run(10);
    chk("fill_fires", 64'(fires), DEPTH);
    irdy = 1; run(8);
    // Memory not ready for 5 cycles.
    rdy = 0; run(5);
    rdy = 1; run(6);
    // Redirect with slower memory while the buffer is partly full.
    lat_lo = 3; lat_hi = 3; irdy = 0;
    run(5);
    redirect_to(32'h100);
    irdy = 1; run(12);
    // Back-to-back redirects: only the last one counts.
    redir = 1; redir_pc = 32'h200; step();
    redir_pc = 32'h300; step();
    redir = 0; run(12);
    // Address wrap at the top of the space.
    lat_lo = 1; lat_hi = 2;
    redirect_to(32'hFFFFFFF8);
    run(8);
    chk("addr_wrap", saw_wrap, 1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rdy      = ($urandom_range(0, 3) != 0);
      irdy     = ($urandom_range(0, 9) < 7);
      redir    = ($urandom_range(0, 19) == 0);
      redir_pc = $urandom() & 32'hFFFFFFFC;
      lat_lo   = 1;
      lat_hi   = $urandom_range(1, 4);
      rst_drv  = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_drv = 1; redir = 0;
    run(2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
